// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall/flush control for the 5-stage core: load-use stalls, data-memory
// waits with timeout, and taken-branch flushes. Optional PIPE_PERF_CNT_EN adds perf counters.
module pipe_hazard_ctrl #(
  parameter int REG_W        = 3,
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] ID_rs,
  input  logic [REG_W-1:0] ID_rt,
  input  logic             ID_uses_rt,
  input  logic             EX_memread,
  input  logic [REG_W-1:0] EX_rt,
  input  logic             mem_req,
  input  logic             mem_ack,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_bubble,
  output logic             exmem_write,
  output logic             mem_err,
  output logic [1:0]       state
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [15:0]      stall_cycles,
  output logic [15:0]      flush_cycles
`endif
);

  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, FLUSH = 2'd2, UNUSED = 2'd3} state_t;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_write;
    logic idex_bubble;
    logic exmem_write;
  } ctl_t;

  localparam ctl_t CTL_RUN    = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  localparam ctl_t CTL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam ctl_t CTL_RESET  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  localparam logic [7:0] TMO  = 8'(MEM_TIMEOUT);
  localparam logic [2:0] FLC  = 3'(FLUSH_CYCLES);

  state_t     state_q, state_d;
  logic [7:0] wait_cnt, wait_d;
  logic [2:0] flush_cnt, flush_d;
  logic       err_set;
  logic       lu_hz;
  ctl_t       ctl;

  assign lu_hz = id_valid & EX_memread & (EX_rt != '0) &
                 ((EX_rt == ID_rs) | (ID_uses_rt & (EX_rt == ID_rt)));

  always_comb begin
    state_d = state_q;
    wait_d  = wait_cnt;
    flush_d = flush_cnt;
    err_set = 1'b0;
    ctl     = CTL_RUN;
    case (state_q)
      RUN: begin
        // A pending memory wait freezes everything, EX included, so a concurrent
        // branch stays in EX and is taken once the pipe moves again.
        if (mem_req & ~mem_ack) begin
          ctl     = CTL_FREEZE;
          state_d = MEM_WAIT;
          wait_d  = 8'd1;
        end else if (branch_taken) begin
          ctl.ifid_flush  = 1'b1;
          ctl.idex_bubble = 1'b1;
          state_d         = FLUSH;
          flush_d         = 3'd1;
        end else if (lu_hz) begin
          ctl.pc_write    = 1'b0;
          ctl.ifid_write  = 1'b0;
          ctl.idex_bubble = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (mem_ack) begin
          state_d = RUN;
        end else if (wait_cnt == TMO) begin
          state_d = RUN;
          err_set = 1'b1;
        end else begin
          ctl    = CTL_FREEZE;
          wait_d = wait_cnt + 8'd1;
        end
      end
      FLUSH: begin
        ctl.ifid_flush  = 1'b1;
        ctl.idex_bubble = 1'b1;
        if (flush_cnt == FLC) state_d = RUN;
        else                  flush_d = flush_cnt + 3'd1;
      end
      default: state_d = RUN;
    endcase
    if (rst) ctl = CTL_RESET;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      wait_cnt  <= '0;
      flush_cnt <= '0;
      mem_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_cnt  <= wait_d;
      flush_cnt <= flush_d;
      if (err_set) mem_err <= 1'b1;
    end
  end

  assign pc_write    = ctl.pc_write;
  assign ifid_write  = ctl.ifid_write;
  assign ifid_flush  = ctl.ifid_flush;
  assign idex_write  = ctl.idex_write;
  assign idex_bubble = ctl.idex_bubble;
  assign exmem_write = ctl.exmem_write;
  assign state       = state_q;

`ifdef PIPE_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_cycles <= '0;
    end else begin
      if (!ctl.pc_write && stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 16'd1;
      if (ctl.ifid_flush && flush_cycles != 16'hFFFF) flush_cycles <= flush_cycles + 16'd1;
    end
  end
`endif

endmodule
